// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches to instruction memory,
// tracks outstanding requests and queues returned instructions with their PCs for the IF stage.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic [31:0] boot_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        busy_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   rsp_addr_q, rsp_addr_d;
  logic [31:0]   tgt_q, tgt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          branch_pend_q, branch_pend_d;
  logic          hold_q, hold_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic        run, req, grant, stall, rsp, drop, push, pop, redirect;
  logic [31:0] target;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{boot_addr_i[1:0], branch_addr_i[1:0]};

  assign run      = (state_q == RUN);
  assign redirect = run & branch_i;
  assign target   = {branch_addr_i[31:2], 2'b00};

  // A request left ungranted is held (hold_q) independent of enable, space or redirects.
  assign req   = hold_q
               | (run & fetch_enable_i
                  & (32'(outst_q) < MAX_OUTSTANDING)
                  & ((32'(cnt_q) + 32'(outst_q)) < DEPTH));
  assign grant = req & instr_gnt_i;
  assign stall = req & ~instr_gnt_i;
  assign rsp   = instr_rvalid_i & run;
  assign drop  = rsp & (discard_q != '0);
  assign push  = rsp & ~drop & ~redirect;
  assign pop   = (cnt_q != '0) & ready_i & ~redirect;

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    rsp_addr_d    = rsp_addr_q;
    tgt_d         = tgt_q;
    branch_pend_d = branch_pend_q;
    hold_d        = stall;
    outst_d       = outst_q + CW'(grant) - CW'(rsp);
    discard_d     = discard_q;

    if (!run) begin
      if (fetch_enable_i) begin
        state_d      = RUN;
        fetch_addr_d = {boot_addr_i[31:2], 2'b00};
        rsp_addr_d   = {boot_addr_i[31:2], 2'b00};
      end
    end else begin
      if (push) rsp_addr_d = rsp_addr_q + 32'd4;
      if (grant) begin
        fetch_addr_d  = branch_pend_q ? tgt_q : fetch_addr_q + 32'd4;
        branch_pend_d = 1'b0;
      end
      discard_d = discard_q - CW'(drop) + CW'(grant & branch_pend_q);
      // A stalled request must keep its address; it is retired as stale once granted.
      if (redirect) begin
        discard_d     = outst_d;
        rsp_addr_d    = target;
        tgt_d         = target;
        branch_pend_d = stall;
        if (!stall) fetch_addr_d = target;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (redirect) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + NW'(push) - NW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      fetch_addr_q  <= '0;
      rsp_addr_q    <= '0;
      tgt_q         <= '0;
      branch_pend_q <= 1'b0;
      hold_q        <= 1'b0;
      outst_q       <= '0;
      discard_q     <= '0;
      cnt_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      rsp_addr_q    <= rsp_addr_d;
      tgt_q         <= tgt_d;
      branch_pend_q <= branch_pend_d;
      hold_q        <= hold_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
      cnt_q         <= cnt_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= rsp_addr_q;
      fifo_data_q[wptr_q] <= instr_rdata_i;
    end
  end

  assign valid_o      = (cnt_q != '0);
  assign rdata_o      = valid_o ? fifo_data_q[rptr_q] : '0;
  assign addr_o       = valid_o ? fifo_addr_q[rptr_q] : '0;
  assign busy_o       = (outst_q != '0) | (discard_q != '0);
  assign instr_req_o  = req;
  assign instr_addr_o = fetch_addr_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed scenarios plus a transaction-level model
// (queues of requests and buffered instructions) checked every cycle.
module tb_instr_prefetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic        clk_i, rst_i;
  logic        fetch_enable_i, branch_i, ready_i;
  logic [31:0] boot_addr_i, branch_addr_i;
  logic        valid_o, busy_o, instr_req_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_enable_i(fetch_enable_i),
    .boot_addr_i(boot_addr_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

  req_t        m_out[$];
  ent_t        m_fifo[$];
  logic [31:0] memq[$];
  bit          m_run, m_held, m_stale_pend, m_req;
  logic [31:0] m_next, m_tgt;

  int n_chk = 0;
  int n_fail = 0;

  bit          v_rst, v_en, v_branch, v_ready, v_gnt, v_rv;
  logic [31:0] v_baddr, v_boot;
  bit          s_grant;
  logic [31:0] s_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out.delete();
    m_fifo.delete();
    m_run = 0; m_held = 0; m_stale_pend = 0; m_req = 0;
    m_next = '0; m_tgt = '0;
  endtask

  task automatic model_step();
    bit   gr, br;
    req_t r;
    ent_t e;
    gr = m_req && instr_gnt_i;
    br = branch_i && m_run;
    if (!m_run) begin
      if (fetch_enable_i) begin
        m_run  = 1;
        m_next = {boot_addr_i[31:2], 2'b00};
      end
      m_held = 0;
      return;
    end
    if (!br && ready_i && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (instr_rvalid_i && m_out.size() > 0) begin
      r = m_out.pop_front();
      if (!r.stale && !br) begin
        e.addr = r.addr; e.data = mdata(r.addr);
        m_fifo.push_back(e);
      end
    end
    if (gr) begin
      r.addr = m_next; r.stale = m_stale_pend;
      m_out.push_back(r);
      m_next = m_stale_pend ? m_tgt : m_next + 32'd4;
      m_stale_pend = 0;
    end
    m_held = m_req && !instr_gnt_i;
    if (br) begin
      foreach (m_out[i]) m_out[i].stale = 1;
      m_fifo.delete();
      if (m_held) begin
        m_stale_pend = 1;
        m_tgt = {branch_addr_i[31:2], 2'b00};
      end else begin
        m_next = {branch_addr_i[31:2], 2'b00};
      end
    end
  endtask

  task automatic compare();
    if (rst_i) model_reset();
    m_req = m_held || (m_run && fetch_enable_i && m_out.size() < MAXO
                       && (m_fifo.size() + m_out.size()) < DEPTH);
    chk1("valid", valid_o, m_fifo.size() != 0);
    chk("head_addr", addr_o, (m_fifo.size() != 0) ? m_fifo[0].addr : 32'h0);
    chk("head_data", rdata_o, (m_fifo.size() != 0) ? m_fifo[0].data : 32'h0);
    chk1("req", instr_req_o, m_req);
    chk("req_addr", instr_addr_o, m_next);
    chk1("busy", busy_o, m_out.size() != 0);
  endtask

  task automatic cycle();
    @(posedge clk_i);
    if (rst_i) begin
      model_reset();
      memq.delete();
    end else begin
      if (instr_rvalid_i && memq.size() > 0) void'(memq.pop_front());
      if (s_grant) memq.push_back(s_addr);
      model_step();
    end
    @(negedge clk_i);
    rst_i          = v_rst;
    fetch_enable_i = v_en;
    branch_i       = v_branch;
    branch_addr_i  = v_baddr;
    boot_addr_i    = v_boot;
    ready_i        = v_ready;
    instr_gnt_i    = v_gnt;
    if (v_rv && !rst_i && memq.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mdata(memq[0]);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
    #1;
    compare();
    s_grant = instr_req_o && instr_gnt_i;
    s_addr  = instr_addr_o;
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_addr);
    int unsigned k;
    k = 0;
    while (!valid_o && k < 20) begin
      cycle();
      k++;
    end
    if (!valid_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: valid_o never rose, expected addr %h", name, exp_addr);
    end else begin
      chk(name, addr_o, exp_addr);
      chk({name, "_data"}, rdata_o, mdata(exp_addr));
    end
  endtask

  logic [31:0] gpat, rpat, ypat;

  initial begin
    rst_i = 1'b1; fetch_enable_i = 0; branch_i = 0; ready_i = 0;
    boot_addr_i = '0; branch_addr_i = '0; instr_gnt_i = 0;
    instr_rvalid_i = 0; instr_rdata_i = '0;
    v_rst = 1; v_en = 0; v_branch = 0; v_ready = 0; v_gnt = 0; v_rv = 0;
    v_baddr = '0; v_boot = 32'h80;
    s_grant = 0; s_addr = '0;
    model_reset();
    cycles(3);
    chk1("rst_valid", valid_o, 1'b0);
    chk1("rst_req", instr_req_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk("rst_req_addr", instr_addr_o, 32'h0);
    v_rst = 0;
    cycle();

    // Boot stream with the IF stage stalled: fill the buffer.
    v_en = 1; v_gnt = 1; v_rv = 1; v_ready = 0;
    cycle();
    chk1("idle_req", instr_req_o, 1'b0);
    cycle();
    chk1("boot_req", instr_req_o, 1'b1);
    chk("boot_addr", instr_addr_o, 32'h80);
    cycle();
    chk("second_addr", instr_addr_o, 32'h84);
    chk1("lat_valid_n1", valid_o, 1'b0);
    cycle();
    chk1("lat_valid_n2", valid_o, 1'b1);
    chk("first_head", addr_o, 32'h80);
    chk("first_data", rdata_o, mdata(32'h80));
    cycles(6);
    chk1("full_valid", valid_o, 1'b1);
    chk("full_head", addr_o, 32'h80);
    chk1("full_req", instr_req_o, 1'b0);
    chk("full_next", instr_addr_o, 32'h90);
    chk1("full_busy", busy_o, 1'b0);
    v_ready = 1;
    for (int unsigned i = 0; i < 6; i++) begin
      cycle();
      chk1("drain_valid", valid_o, 1'b1);
      chk("drain_order", addr_o, 32'h80 + 32'(4 * i));
    end

    // Redirect with two outstanding requests.
    v_rv = 0;
    cycles(4);
    chk1("two_out_busy", busy_o, 1'b1);
    chk1("two_out_req", instr_req_o, 1'b0);
    v_branch = 1; v_baddr = 32'h203; v_rv = 1;
    cycle();
    v_branch = 0;
    cycle();
    chk1("br_flush", valid_o, 1'b0);
    chk("br_target", instr_addr_o, 32'h200);
    chk1("br_busy", busy_o, 1'b1);
    wait_valid("br_first", 32'h200);

    // Held request redirected: address stable, response discarded.
    v_en = 0;
    cycles(6);
    chk1("drain_busy", busy_o, 1'b0);
    chk1("drain_empty", valid_o, 1'b0);
    v_branch = 1; v_baddr = 32'h90;
    cycle();
    v_branch = 0;
    cycle();
    chk("idle_br_addr", instr_addr_o, 32'h90);
    chk1("idle_br_req", instr_req_o, 1'b0);
    v_gnt = 0; v_en = 1;
    cycle();
    chk1("hold_req1", instr_req_o, 1'b1);
    chk("hold_addr1", instr_addr_o, 32'h90);
    v_branch = 1; v_baddr = 32'h400; v_en = 0;
    cycle();
    chk1("hold_req2", instr_req_o, 1'b1);
    chk("hold_addr2", instr_addr_o, 32'h90);
    v_branch = 0;
    cycle();
    chk1("hold_req3", instr_req_o, 1'b1);
    chk("hold_addr3", instr_addr_o, 32'h90);
    v_gnt = 1; v_en = 1;
    cycle();
    chk("hold_gnt_addr", instr_addr_o, 32'h90);
    cycle();
    chk("hold_then_tgt", instr_addr_o, 32'h400);
    chk1("hold_busy", busy_o, 1'b1);
    wait_valid("hold_first", 32'h400);

    // Fetch disabled with two outstanding: both responses land in the buffer.
    v_en = 0; v_ready = 1; v_rv = 1;
    cycles(6);
    v_en = 1; v_rv = 0; v_ready = 0;
    cycles(4);
    chk1("dis_busy_before", busy_o, 1'b1);
    v_en = 0; v_rv = 1;
    cycles(4);
    chk1("dis_busy_after", busy_o, 1'b0);
    chk1("dis_valid", valid_o, 1'b1);
    chk1("dis_req", instr_req_o, 1'b0);

    // Asynchronous reset mid-stream.
    v_en = 1; v_rv = 0;
    cycles(3);
    rst_i = 1'b1; v_rst = 1;
    #1;
    chk1("arst_valid", valid_o, 1'b0);
    chk1("arst_req", instr_req_o, 1'b0);
    chk1("arst_busy", busy_o, 1'b0);
    chk("arst_req_addr", instr_addr_o, 32'h0);
    model_reset();
    memq.delete();
    instr_rvalid_i = 0;
    instr_rdata_i  = '0;
    s_grant = 0;
    cycles(2);
    v_rst = 0; v_boot = 32'h1003; v_en = 1; v_ready = 1; v_rv = 1; v_gnt = 1;
    cycle();
    cycle();
    chk1("restart_req", instr_req_o, 1'b1);
    chk("restart_addr", instr_addr_o, 32'h1000);
    wait_valid("restart_first", 32'h1000);

    // Mixed handshake patterns with back-to-back and isolated redirects.
    gpat = 32'b1101_0111_0010_1111_1011_0110_1110_1001;
    rpat = 32'b0111_1010_1101_1100_1111_0011_0101_1110;
    ypat = 32'b1011_1100_0111_0101_1001_1110_0110_1011;
    for (int unsigned i = 0; i < 32; i++) begin
      v_gnt    = gpat[i];
      v_rv     = rpat[i];
      v_ready  = ypat[i];
      v_branch = (i == 9 || i == 10 || i == 20);
      v_baddr  = 32'h3001 + 32'(i << 8);
      cycle();
    end
    v_branch = 0; v_gnt = 1; v_rv = 1; v_ready = 1; v_en = 0;
    cycles(8);
    chk1("final_busy", busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
